// File: rtl/hs_unit_pkg.sv
// hs_unit_pkg: shared state encoding and depth for the handshake register slice
package hs_unit_pkg;
  localparam int REG_SLICE_DEPTH = 2;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } reg_slice_state_t;
endpackage

// File: rtl/hs_unit_reg_slice.sv
// hs_unit_reg_slice: two-entry skid-buffer register slice registering both valid/data and ready paths
module hs_unit_reg_slice
  import hs_unit_pkg::*;
#(
  parameter type DATA_TYPE = logic,
  parameter DATA_TYPE RESET_VALUE = DATA_TYPE'(1'b0)
) (
  input  logic                                     clk,
  input  logic                                     aresetn,
  input  logic                                     flush,
  input  logic                                     s_valid,
  output logic                                     s_ready,
  input  DATA_TYPE                                 s_data,
  output logic                                     m_valid,
  input  logic                                     m_ready,
  output DATA_TYPE                                 m_data,
  output logic [$clog2(REG_SLICE_DEPTH+1)-1:0]     occupancy
);
  reg_slice_state_t state, state_nxt;
  DATA_TYPE main_q, skid_q;
  logic push, pop, load_main, load_skid;
  always_comb begin
    s_ready   = aresetn && state != ST_FULL;
    m_valid   = aresetn && state != ST_EMPTY;
    push      = s_valid && s_ready;
    pop       = m_valid && m_ready;
    load_main = !flush && ((state == ST_EMPTY && push) || (state == ST_BUSY && push && pop) || (state == ST_FULL && pop));
    load_skid = !flush && state == ST_BUSY && push && !pop;
    state_nxt = flush ? ST_EMPTY :
                state == ST_EMPTY ? (push ? ST_BUSY : ST_EMPTY) :
                state == ST_BUSY  ? (push && !pop ? ST_FULL : pop && !push ? ST_EMPTY : ST_BUSY) :
                (pop ? ST_BUSY : ST_FULL);
  end
  always_ff @(posedge clk) begin
    if (!aresetn) state <= ST_EMPTY;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      main_q <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else begin
      if (load_main) main_q <= state == ST_FULL ? skid_q : s_data;
      if (load_skid) skid_q <= s_data;
    end
  end
  assign m_data    = main_q;
  assign occupancy = state;
endmodule

// File: tb/tb_hs_unit_reg_slice.sv
// tb_hs_unit_reg_slice: scoreboard bench for the skid-buffer register slice
module tb_hs_unit_reg_slice;
  logic clk = 1'b0;
  logic aresetn, flush, s_valid, s_ready, m_valid, m_ready;
  logic [7:0] s_data, m_data;
  logic [1:0] occupancy;
  logic [7:0] q[$];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  hs_unit_reg_slice #(.DATA_TYPE(logic [7:0]), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .aresetn(aresetn), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .occupancy(occupancy)
  );
  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    int n;
    logic [7:0] e;
    n = q.size();
    if (!aresetn) begin
      chk("rst_gate_s_ready", int'(s_ready), 0);
      chk("rst_gate_m_valid", int'(m_valid), 0);
      q.delete();
    end else begin
      chk("mon_occupancy", int'(occupancy), n);
      chk("mon_s_ready", int'(s_ready), int'(n < 2));
      chk("mon_m_valid", int'(m_valid), int'(n > 0));
      if (m_ready && n > 0) begin
        e = q.pop_front();
        chk("mon_m_data", int'(m_data), int'(e));
      end
      if (flush) q.delete();
      else if (s_valid && n < 2) q.push_back(s_data);
    end
  end
  initial begin
    logic acc;
    aresetn = 1'b0; flush = 1'b0; s_valid = 1'b1; s_data = 8'hEE; m_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("reset_s_ready", int'(s_ready), 0);
      chk("reset_m_valid", int'(m_valid), 0);
      chk("reset_occupancy", int'(occupancy), 0);
    end
    aresetn = 1'b1;
    #1;
    chk("release_s_ready", int'(s_ready), 1);
    tick();
    chk("release_first_accept_occ", int'(occupancy), 1);
    s_valid = 1'b0; m_ready = 1'b1;
    tick();
    chk("release_drain_occ", int'(occupancy), 0);
    s_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_data = 8'(i);
      tick();
      chk("stream_occ", int'(occupancy), 1);
      chk("stream_m_data", int'(m_data), i);
    end
    s_valid = 1'b0;
    tick();
    chk("stream_end_occ", int'(occupancy), 0);
    s_valid = 1'b1; s_data = 8'hA0; m_ready = 1'b1;
    tick();
    s_data = 8'hA1;
    tick();
    s_data = 8'hA2; m_ready = 1'b0;
    tick();
    chk("bp_full_occ", int'(occupancy), 2);
    chk("bp_full_s_ready", int'(s_ready), 0);
    chk("bp_full_m_data", int'(m_data), 8'hA1);
    s_valid = 1'b0; m_ready = 1'b1;
    tick();
    chk("bp_pop1_s_ready", int'(s_ready), 1);
    chk("bp_pop1_m_data", int'(m_data), 8'hA2);
    tick();
    chk("bp_drained_occ", int'(occupancy), 0);
    s_valid = 1'b1; s_data = 8'h55; m_ready = 1'b0;
    tick();
    s_data = 8'h66;
    tick();
    chk("flush_fill_occ", int'(occupancy), 2);
    s_data = 8'h99; flush = 1'b1;
    tick();
    chk("flush_m_valid", int'(m_valid), 0);
    chk("flush_occ", int'(occupancy), 0);
    chk("flush_s_ready", int'(s_ready), 1);
    flush = 1'b0; s_data = 8'h77; m_ready = 1'b1;
    tick();
    chk("flush_next_m_data", int'(m_data), 8'h77);
    s_valid = 1'b0;
    tick();
    s_valid = 1'b1; s_data = 8'h11; m_ready = 1'b0;
    tick();
    chk("midrst_busy_occ", int'(occupancy), 1);
    s_data = 8'h22; m_ready = 1'b1; aresetn = 1'b0;
    tick();
    aresetn = 1'b1; s_valid = 1'b0;
    #1;
    chk("midrst_occ", int'(occupancy), 0);
    chk("midrst_m_valid", int'(m_valid), 0);
    s_valid = 1'b1; s_data = 8'h33;
    tick();
    chk("midrst_next_m_data", int'(m_data), 8'h33);
    s_valid = 1'b0;
    tick();
    acc = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      if (!s_valid || acc || flush) begin
        s_valid = $urandom_range(0, 1) == 1;
        s_data = 8'($urandom);
      end
      m_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 99) == 0;
      @(negedge clk);
      acc = s_valid && s_ready;
      tick();
    end
    s_valid = 1'b0; flush = 1'b0; m_ready = 1'b1;
    repeat (3) tick();
    chk("soak_drained_occ", int'(occupancy), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
